// File: rtl/dynamic_buff.sv
// rtl/dynamic_buff.sv - multi-FIFO buffer sharing one linked-list entry pool
//
// Purpose:
//   NUMFIFO logical FIFOs share NUMADDR data entries. Each FIFO is a linked
//   list (head, tail, count). Each entry has a next pointer. Unused entries
//   sit on a free list that is built by an INIT pass after reset.
//   Optional macro DYNAMIC_BUFF_RECYCLE_EN: a push while full is accepted
//   when a legal pop happens in the same cycle. The popped entry is handed
//   straight to the push.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   ready       high once the free list is built
//   push/pu_prt/pu_din   append pu_din to FIFO pu_prt
//   pop/po_prt/po_dout   remove the head of FIFO po_prt; data shown the same cycle
//   full        free list empty
//   free_cnt    number of free entries
//   fifo_empty  per-FIFO empty flags
//   err         one-cycle pulse after an illegal push or pop
module dynamic_buff #(
  parameter int NUMADDR = 32,
  parameter int BITDATA = 4,
  parameter int NUMFIFO = 8,
  parameter int BITADDR = $clog2(NUMADDR),
  parameter int BITFIFO = $clog2(NUMFIFO),
  parameter int BITCNT  = $clog2(NUMADDR + 1)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ready,
  input  logic               push,
  input  logic [BITFIFO-1:0] pu_prt,
  input  logic [BITDATA-1:0] pu_din,
  input  logic               pop,
  input  logic [BITFIFO-1:0] po_prt,
  output logic [BITDATA-1:0] po_dout,
  output logic               full,
  output logic [BITCNT-1:0]  free_cnt,
  output logic [NUMFIFO-1:0] fifo_empty,
  output logic               err
);

  localparam logic [BITADDR-1:0] LAST = BITADDR'(NUMADDR - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state_q;
  logic [BITADDR-1:0] init_q;
  logic [BITADDR-1:0] next_q [NUMADDR];
  logic [BITDATA-1:0] data_q [NUMADDR];
  logic [BITADDR-1:0] head_q [NUMFIFO];
  logic [BITADDR-1:0] tail_q [NUMFIFO];
  logic [BITCNT-1:0]  cnt_q  [NUMFIFO];
  logic [BITADDR-1:0] free_head_q;
  logic [BITCNT-1:0]  free_cnt_q;
  logic               ready_q;
  logic               err_q;

  logic [BITCNT-1:0]  cnt_po;
  logic [BITCNT-1:0]  cnt_pu;
  logic [BITADDR-1:0] h;
  logic [BITADDR-1:0] a;
  logic [BITADDR-1:0] tail_pu;
  logic               is_full;
  logic               pop_ok;
  logic               push_ok;
  logic               recycle;
  logic               same;
  logic               op_err;

  always_comb begin
    cnt_po  = cnt_q[po_prt];
    cnt_pu  = cnt_q[pu_prt];
    h       = head_q[po_prt];
    tail_pu = tail_q[pu_prt];
    is_full = (free_cnt_q == '0);
    pop_ok  = ready_q & pop & (cnt_po != '0);
`ifdef DYNAMIC_BUFF_RECYCLE_EN
    push_ok = ready_q & push & (~is_full | pop_ok);
`else
    push_ok = ready_q & push & ~is_full;
`endif
    // Only reachable when full: the push reuses the entry freed by the pop.
    recycle = push_ok & is_full;
    a       = recycle ? h : free_head_q;
    same    = push_ok & pop_ok & (pu_prt == po_prt);
    op_err  = ready_q & ((push & ~push_ok) | (pop & ~pop_ok));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_q      <= '0;
      free_head_q <= '0;
      free_cnt_q  <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < NUMFIFO; i++) cnt_q[i] <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          // Chain every entry into the free list. The last next pointer is never followed.
          next_q[init_q] <= (init_q == LAST) ? '0 : init_q + BITADDR'(1);
          free_cnt_q     <= free_cnt_q + BITCNT'(1);
          init_q         <= init_q + BITADDR'(1);
          if (init_q == LAST) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          err_q <= op_err;
          if (pop_ok) begin
            head_q[po_prt] <= next_q[h];
            cnt_q[po_prt]  <= cnt_po - BITCNT'(1);
          end
          if (push_ok) begin
            data_q[a]      <= pu_din;
            tail_q[pu_prt] <= a;
            if (same) begin
              // Count is unchanged. With one entry, the old tail is the popped head,
              // so the new entry becomes both head and tail and the link is skipped.
              cnt_q[pu_prt] <= cnt_pu;
              if (cnt_po == BITCNT'(1)) head_q[pu_prt] <= a;
              else next_q[tail_pu] <= a;
            end else begin
              cnt_q[pu_prt] <= cnt_pu + BITCNT'(1);
              if (cnt_pu == '0) head_q[pu_prt] <= a;
              else next_q[tail_pu] <= a;
            end
          end
          if (!recycle) begin
            if (push_ok && pop_ok) begin
              // The popped entry replaces the allocated entry at the free-list head.
              next_q[h]   <= next_q[a];
              free_head_q <= h;
            end else if (push_ok) begin
              free_head_q <= next_q[a];
              free_cnt_q  <= free_cnt_q - BITCNT'(1);
            end else if (pop_ok) begin
              next_q[h]   <= free_head_q;
              free_head_q <= h;
              free_cnt_q  <= free_cnt_q + BITCNT'(1);
            end
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign ready    = ready_q;
  assign err      = err_q;
  assign full     = is_full;
  assign free_cnt = free_cnt_q;
  assign po_dout  = data_q[h];

  for (genvar g = 0; g < NUMFIFO; g++) begin : g_empty
    assign fifo_empty[g] = (cnt_q[g] == '0);
  end

endmodule

// File: tb/tb_dynamic_buff.sv
// tb/tb_dynamic_buff.sv - scoreboard bench for dynamic_buff
module tb_dynamic_buff;

  localparam int NA = 32;
  localparam int BD = 4;
  localparam int NF = 8;
  localparam int BF = 3;
  localparam int BC = 6;
`ifdef DYNAMIC_BUFF_RECYCLE_EN
  localparam bit RECYCLE = 1'b1;
`else
  localparam bit RECYCLE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic          push;
  logic [BF-1:0] pu_prt;
  logic [BD-1:0] pu_din;
  logic          pop;
  logic [BF-1:0] po_prt;
  logic [BD-1:0] po_dout;
  logic          full;
  logic [BC-1:0] free_cnt;
  logic [NF-1:0] fifo_empty;
  logic          err;

  always #5 clk = ~clk;

  dynamic_buff #(.NUMADDR(NA), .BITDATA(BD), .NUMFIFO(NF)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .push(push), .pu_prt(pu_prt), .pu_din(pu_din),
    .pop(pop), .po_prt(po_prt), .po_dout(po_dout),
    .full(full), .free_cnt(free_cnt), .fifo_empty(fifo_empty), .err(err)
  );

  int passed = 0;
  int total  = 0;

  logic [BD-1:0] pop_q[$];
  logic          pop_chk = 1'b0;
  logic          exp_err = 1'b0;
  logic          mon_on  = 1'b0;

  logic [BD-1:0] mdata [NF][64];
  int            mh [NF];
  int            mt [NF];

  function automatic int mcnt(input int f);
    return mt[f] - mh[f];
  endfunction

  function automatic int mfree();
    int s = NA;
    for (int i = 0; i < NF; i++) s -= mt[i] - mh[i];
    return s;
  endfunction

  function automatic logic [NF-1:0] memp();
    logic [NF-1:0] v = '0;
    for (int i = 0; i < NF; i++) v[i] = (mt[i] == mh[i]);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (pop_chk) begin
        if (pop_q.size() == 0) check("pop_q_empty", 1, 0);
        else check("po_dout", int'(po_dout), int'(pop_q.pop_front()));
      end
      if (err || exp_err) check("err", int'(err), int'(exp_err));
      check("free_cnt", int'(free_cnt), mfree());
      check("full", int'(full), int'(mfree() == 0));
      check("fifo_empty", int'(fifo_empty), int'(memp()));
    end
  end

  task automatic op(input bit dpu, input int pp, input logic [BD-1:0] din,
                    input bit dpo, input int po);
    bit pop_ok, push_ok, bad;
    pop_ok  = dpo && (mcnt(po) > 0);
    push_ok = dpu && ((mfree() > 0) || (RECYCLE && pop_ok));
    bad     = (dpu && !push_ok) || (dpo && !pop_ok);
    push = dpu; pu_prt = BF'(pp); pu_din = din;
    pop  = dpo; po_prt = BF'(po); pop_chk = pop_ok;
    if (pop_ok) pop_q.push_back(mdata[po][mh[po] % 64]);
    @(posedge clk);
    if (pop_ok) mh[po]++;
    if (push_ok) begin
      mdata[pp][mt[pp] % 64] = din;
      mt[pp]++;
    end
    exp_err = bad;
    #1;
    push = 1'b0; pop = 1'b0; pop_chk = 1'b0;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("init_cycles", n, NA);
    check("ready_after_init", int'(ready), 1);
    check("free_cnt_after_init", int'(free_cnt), NA);
    check("full_after_init", int'(full), 0);
    check("empty_after_init", int'(fifo_empty), 255);
    check("err_after_init", int'(err), 0);
  endtask

  task automatic check_reset_state();
    check("rst_ready", int'(ready), 0);
    check("rst_err", int'(err), 0);
    check("rst_free_cnt", int'(free_cnt), 0);
    check("rst_full", int'(full), 1);
    check("rst_fifo_empty", int'(fifo_empty), 255);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      mh[i] = 0;
      mt[i] = 0;
    end
    pop_q.delete();
    exp_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0;
    pu_prt = '0; po_prt = '0; pu_din = '0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state();
    wait_init();
    @(posedge clk);
    #1 mon_on = 1'b1;

    // basic push/pop on FIFO 2
    op(1, 2, 4'h3, 0, 0);
    op(1, 2, 4'h7, 0, 0);
    op(1, 2, 4'hA, 0, 0);
    op(0, 0, 4'h0, 1, 2);
    op(0, 0, 4'h0, 1, 2);
    op(0, 0, 4'h0, 1, 2);
    check("fifo2_empty", int'(fifo_empty[2]), 1);
    check("fifo2_free_cnt", int'(free_cnt), NA);

    // fill the whole pool through FIFO 5, overflow once, drain in order
    for (int i = 0; i < NA; i++) op(1, 5, BD'(i), 0, 0);
    check("fill_full", int'(full), 1);
    check("fill_free_cnt", int'(free_cnt), 0);
    op(1, 5, 4'hF, 0, 0);
    check("overflow_err", int'(err), 1);
    op(0, 0, 4'h0, 0, 0);
    check("overflow_err_clears", int'(err), 0);
    for (int i = 0; i < NA; i++) op(0, 0, 4'h0, 1, 5);
    check("drain_empty5", int'(fifo_empty[5]), 1);

    // interleaved traffic on FIFOs 0/1/7, including simultaneous ops
    op(1, 0, 4'h1, 0, 0);
    op(1, 1, 4'h2, 0, 0);
    op(1, 7, 4'h3, 0, 0);
    op(1, 0, 4'h4, 0, 0);
    op(1, 7, 4'h5, 0, 0);
    op(1, 1, 4'h6, 0, 0);
    op(1, 0, 4'h7, 0, 0);
    op(0, 0, 4'h0, 1, 7);
    op(1, 1, 4'h8, 1, 0);
    op(1, 0, 4'h9, 1, 0);
    op(1, 7, 4'hB, 1, 1);
    op(0, 0, 4'h0, 1, 1);
    while (mcnt(0) > 0) op(0, 0, 4'h0, 1, 0);
    while (mcnt(7) > 0) op(0, 0, 4'h0, 1, 7);
    while (mcnt(1) > 0) op(0, 0, 4'h0, 1, 1);
    check("interleave_all_empty", int'(fifo_empty), 255);

    // same-FIFO push+pop with one entry, then pop of an empty FIFO
    op(1, 4, 4'h9, 0, 0);
    op(1, 4, 4'hC, 1, 4);
    check("fifo4_not_empty", int'(fifo_empty[4]), 0);
    op(0, 0, 4'h0, 1, 4);
    op(0, 0, 4'h0, 1, 4);
    check("pop_empty_err", int'(err), 1);

    // fill via FIFO 1, then push FIFO 3 together with pop FIFO 1
    for (int i = 0; i < NA; i++) op(1, 1, BD'(i ^ 5), 0, 0);
    op(1, 3, 4'hE, 1, 1);
    check("full_push_pop_err", int'(err), RECYCLE ? 0 : 1);
    check("full_push_pop_fifo3", int'(fifo_empty[3]), RECYCLE ? 0 : 1);
    op(1, 0, 4'h1, 1, 6);
    check("both_illegal_err", int'(err), 1);
    op(1, 1, 4'hD, 1, 1);
    while (mcnt(1) > 0) op(0, 0, 4'h0, 1, 1);
    while (mcnt(3) > 0) op(0, 0, 4'h0, 1, 3);

    // reset in the middle of traffic
    op(1, 2, 4'h5, 0, 0);
    op(1, 6, 4'h6, 0, 0);
    mon_on = 1'b0;
    push = 1'b1; pu_prt = 3'd0; pu_din = 4'h3;
    pop = 1'b1; po_prt = 3'd2; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; push = 1'b0; pop = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_state();
    wait_init();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
